// File: rtl/act_sched_pkg.sv
// rtl/act_sched_pkg.sv - constants, state encoding and index mapping for the activation LUT scheduler
package act_sched_pkg;

   localparam int DATA_W = 8;
   localparam int FRAC_W = 4;
   localparam int ADDR_W = DATA_W - FRAC_W;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_BASE,
      ST_RD_NEXT,
      ST_CALC,
      ST_RESP
   } state_t;

   // Offset-binary index: flipping the sign bit puts the most negative x at entry 0.
   function automatic logic [ADDR_W-1:0] idx_of(input logic [DATA_W-1:0] x);
      logic [ADDR_W-1:0] hi;
      hi = x[DATA_W-1:FRAC_W];
      return {~hi[ADDR_W-1], hi[ADDR_W-2:0]};
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter, search starts one past the last grant
module rr_arbiter #(
   parameter  int N_REQ = 4,
   localparam int ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req_valid,
   input  logic [ID_W-1:0]  ptr,
   output logic [N_REQ-1:0] grant,
   output logic [ID_W-1:0]  grant_id,
   output logic             grant_valid
);

   logic [ID_W-1:0] cand;

   // N_REQ is a power of two, so the index add wraps naturally; k = N_REQ lands on ptr itself.
   always_comb begin
      grant       = '0;
      grant_id    = '0;
      grant_valid = 1'b0;
      cand        = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = ptr + ID_W'(k);
         if (!grant_valid && req_valid[cand]) begin
            grant_valid = 1'b1;
            grant[cand] = 1'b1;
            grant_id    = cand;
         end
      end
   end

endmodule

// File: rtl/activation_lut_scheduler.sv
// rtl/activation_lut_scheduler.sv - shares one activation ROM and interpolator among N_REQ requesters
module activation_lut_scheduler #(
   parameter  int N_REQ  = 4,
   parameter  int DATA_W = act_sched_pkg::DATA_W,
   parameter  int FRAC_W = act_sched_pkg::FRAC_W,
   parameter  int ADDR_W = act_sched_pkg::ADDR_W,
   localparam int ID_W   = $clog2(N_REQ)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ*DATA_W-1:0] req_x,
   output logic [N_REQ-1:0]        req_ready,
   output logic                    lut_en,
   output logic [ADDR_W-1:0]       lut_addr,
   input  logic [DATA_W-1:0]       lut_data,
   output logic                    resp_valid,
   input  logic                    resp_ready,
   output logic [ID_W-1:0]         resp_id,
   output logic [DATA_W-1:0]       resp_value
);

   import act_sched_pkg::*;

   state_t                       state;
   logic [ID_W-1:0]              ptr;
   logic [ID_W-1:0]              id_q;
   logic [DATA_W-1:0]            x_q;
   logic [DATA_W-1:0]            base_q;
   logic [N_REQ-1:0]             grant;
   logic [ID_W-1:0]              grant_id;
   logic                         grant_valid;
   logic [DATA_W-1:0]            sel_x;
   logic [ADDR_W-1:0]            idx;
   logic [ADDR_W-1:0]            next_idx;
   logic signed [DATA_W-1:0]     diff;
   logic signed [DATA_W+FRAC_W-1:0] prod;
   logic [DATA_W-1:0]            interp;

   rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .req_valid  (req_valid),
      .ptr        (ptr),
      .grant      (grant),
      .grant_id   (grant_id),
      .grant_valid(grant_valid)
   );

   assign req_ready = (state == ST_IDLE) ? grant : '0;
   assign sel_x     = req_x[grant_id*DATA_W +: DATA_W];
   assign idx       = idx_of(x_q);
   assign next_idx  = (idx == '1) ? idx : idx + 1'b1;

   // In CALC lut_data carries the next entry; the sum wraps rather than saturates.
   assign diff   = $signed(lut_data - base_q);
   assign prod   = $signed({{FRAC_W{diff[DATA_W-1]}}, diff}) *
                   $signed({{DATA_W{1'b0}}, x_q[FRAC_W-1:0]});
   assign interp = base_q + DATA_W'(prod >>> FRAC_W);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         ptr        <= ID_W'(N_REQ - 1);
         id_q       <= '0;
         x_q        <= '0;
         base_q     <= '0;
         lut_en     <= 1'b0;
         lut_addr   <= '0;
         resp_valid <= 1'b0;
         resp_id    <= '0;
         resp_value <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (grant_valid) begin
                  x_q      <= sel_x;
                  id_q     <= grant_id;
                  ptr      <= grant_id;
                  lut_en   <= 1'b1;
                  lut_addr <= idx_of(sel_x);
                  state    <= ST_RD_BASE;
               end
            end
            ST_RD_BASE: begin
               lut_addr <= next_idx;
               state    <= ST_RD_NEXT;
            end
            ST_RD_NEXT: begin
               base_q <= lut_data;
               lut_en <= 1'b0;
               state  <= ST_CALC;
            end
            ST_CALC: begin
               resp_value <= interp;
               resp_id    <= id_q;
               resp_valid <= 1'b1;
               state      <= ST_RESP;
            end
            ST_RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  state      <= ST_IDLE;
               end
            end
            default: begin
               lut_en     <= 1'b0;
               resp_valid <= 1'b0;
               state      <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_activation_lut_scheduler.sv
// tb/tb_activation_lut_scheduler.sv - randomized and directed bench for activation_lut_scheduler
module tb_activation_lut_scheduler;

   localparam int N = 4;

   logic          clk;
   logic          rst_n;
   logic [N-1:0]  req_valid;
   logic [N*8-1:0] req_x;
   logic [N-1:0]  req_ready;
   logic          lut_en;
   logic [3:0]    lut_addr;
   logic [7:0]    lut_data;
   logic          resp_valid;
   logic          resp_ready;
   logic [1:0]    resp_id;
   logic [7:0]    resp_value;

   logic [7:0]    rom [16];
   int            checks   = 0;
   int            failures = 0;

   int            phase;
   int            m_ptr;
   int            cur_id;
   logic [7:0]    cur_val;
   int            cur_idx;

   activation_lut_scheduler #(.N_REQ(N), .DATA_W(8), .FRAC_W(4), .ADDR_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_x     (req_x),
      .req_ready (req_ready),
      .lut_en    (lut_en),
      .lut_addr  (lut_addr),
      .lut_data  (lut_data),
      .resp_valid(resp_valid),
      .resp_ready(resp_ready),
      .resp_id   (resp_id),
      .resp_value(resp_value)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      if (lut_en) lut_data <= rom[lut_addr];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic int wrap8(input int v);
      int t;
      t = v & 255;
      return (t >= 128) ? t - 256 : t;
   endfunction

   function automatic int idx_model(input logic [7:0] x);
      return (int'($signed(x)) + 128) / 16;
   endfunction

   // Straight arithmetic on signed integers: linear interpolation between two table entries.
   function automatic logic [7:0] model_val(input logic [7:0] x);
      int xi, idx, rem, b, nx, d, r;
      xi  = int'($signed(x));
      idx = (xi + 128) / 16;
      rem = (xi + 128) % 16;
      b   = int'($signed(rom[idx]));
      nx  = int'($signed(rom[(idx < 15) ? idx + 1 : 15]));
      d   = wrap8(nx - b);
      r   = wrap8(b + ((d * rem) >>> 4));
      return 8'(r);
   endfunction

   function automatic int exp_grant(input logic [N-1:0] v, input int ptr);
      for (int k = 1; k <= N; k++) begin
         if (v[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   always @(negedge clk) begin
      int g;
      logic [N-1:0] em;
      if (!rst_n) begin
         chk("rst_req_ready", req_ready, 0);
         chk("rst_lut_en", lut_en, 0);
         chk("rst_lut_addr", lut_addr, 0);
         chk("rst_resp_valid", resp_valid, 0);
         chk("rst_resp_id", resp_id, 0);
         chk("rst_resp_value", resp_value, 0);
         phase = 0;
         m_ptr = N - 1;
      end else begin
         chk("onehot_ready", 32'($countones(req_ready) <= 1), 1);
         case (phase)
            0: begin
               g  = exp_grant(req_valid, m_ptr);
               em = (g >= 0) ? 4'(1 << g) : 4'b0;
               chk("arb_grant", req_ready, em);
               chk("idle_lut_en", lut_en, 0);
               chk("idle_resp_valid", resp_valid, 0);
               if (g >= 0) begin
                  cur_id  = g;
                  cur_idx = idx_model(req_x[g*8 +: 8]);
                  cur_val = model_val(req_x[g*8 +: 8]);
                  m_ptr   = g;
                  phase   = 1;
               end
            end
            1: begin
               chk("base_lut_en", lut_en, 1);
               chk("base_lut_addr", lut_addr, cur_idx);
               chk("busy_ready", req_ready, 0);
               chk("busy_resp_valid", resp_valid, 0);
               phase = 2;
            end
            2: begin
               chk("next_lut_en", lut_en, 1);
               chk("next_lut_addr", lut_addr, (cur_idx < 15) ? cur_idx + 1 : 15);
               chk("busy_ready", req_ready, 0);
               chk("busy_resp_valid", resp_valid, 0);
               phase = 3;
            end
            3: begin
               chk("calc_lut_en", lut_en, 0);
               chk("busy_ready", req_ready, 0);
               chk("calc_resp_valid", resp_valid, 0);
               phase = 4;
            end
            default: begin
               chk("resp_valid", resp_valid, 1);
               chk("resp_id", resp_id, cur_id);
               chk("resp_value", resp_value, cur_val);
               chk("resp_lut_en", lut_en, 0);
               chk("resp_no_grant", req_ready, 0);
               if (resp_valid && resp_ready) phase = 0;
            end
         endcase
      end
   end

   task automatic single(input int id, input logic [7:0] x, input logic [7:0] expv, input string nm);
      bit seen;
      int lat;
      req_x[id*8 +: 8] = x;
      req_valid[id]    = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 50 && !seen; c++) begin
         @(negedge clk);
         seen = req_ready[id];
      end
      chk({nm, "_accept"}, 32'(seen), 1);
      @(posedge clk);
      #1 req_valid[id] = 1'b0;
      seen = 1'b0;
      lat  = 0;
      for (int c = 0; c < 50 && !seen; c++) begin
         @(negedge clk);
         lat++;
         seen = resp_valid;
      end
      chk({nm, "_latency"}, lat - 1, 3);
      chk({nm, "_value"}, resp_value, expv);
      chk({nm, "_id"}, resp_id, id);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string nm);
      bit done;
      done = 1'b0;
      for (int c = 0; c < 100 && !done; c++) begin
         @(negedge clk);
         done = (phase == 0);
      end
      chk({nm, "_idle"}, 32'(done), 1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          seen;
      int          ng;
      int          gid;
      int          order [5] = '{0, 1, 2, 3, 0};
      logic [N-1:0] acc;

      rst_n      = 1'b0;
      req_valid  = '0;
      req_x      = '0;
      resp_ready = 1'b1;
      lut_data   = '0;
      for (int k = 0; k < 16; k++) rom[k] = 8'(8 * k);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      chk("model_pin_x00", model_val(8'h00), 8'd64);
      chk("model_pin_x08", model_val(8'h08), 8'd68);
      chk("model_pin_x80", model_val(8'h80), 8'd0);
      chk("model_pin_x7f", model_val(8'h7F), 8'd120);

      single(0, 8'h00, 8'd64, "x00");
      single(0, 8'h08, 8'd68, "x08");
      single(1, 8'h80, 8'd0, "x80");
      single(2, 8'h7F, 8'd120, "x7f");

      rom[8] = 8'd100;
      rom[9] = 8'h9C;
      chk("model_pin_wrap", model_val(8'h08), 8'h80);
      single(3, 8'h08, 8'h80, "wrap");
      for (int k = 0; k < 16; k++) rom[k] = 8'(8 * k);

      req_valid = '1;
      ng = 0;
      for (int c = 0; c < 100 && ng < 5; c++) begin
         @(negedge clk);
         if (req_ready != 0) begin
            gid = -1;
            for (int i = 0; i < N; i++) if (req_ready[i]) gid = i;
            chk($sformatf("rr_order%0d", ng), gid, order[ng]);
            ng++;
         end
      end
      chk("rr_count", ng, 5);
      @(posedge clk);
      #1 req_valid = '0;
      wait_idle("rr");

      resp_ready     = 1'b0;
      req_x[15:8]    = 8'h10;
      req_valid[1]   = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 50 && !seen; c++) begin
         @(negedge clk);
         seen = req_ready[1];
      end
      chk("bp_accept", 32'(seen), 1);
      @(posedge clk);
      #1;
      req_valid[1] = 1'b0;
      req_valid[2] = 1'b1;
      req_x[23:16] = 8'h20;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         seen = resp_valid;
      end
      chk("bp_valid", 32'(seen), 1);
      chk("bp_value", resp_value, 8'd72);
      repeat (10) begin
         @(negedge clk);
         chk("bp_hold_valid", resp_valid, 1);
         chk("bp_hold_value", resp_value, 8'd72);
         chk("bp_hold_id", resp_id, 1);
         chk("bp_no_grant", req_ready, 0);
      end
      @(posedge clk);
      #1 resp_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("bp_next_grant", req_ready, 4'b0100);
      @(posedge clk);
      #1 req_valid[2] = 1'b0;
      wait_idle("bp");

      req_x[7:0]   = 8'h00;
      req_valid[0] = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 50 && !seen; c++) begin
         @(negedge clk);
         seen = req_ready[0];
      end
      chk("ar_accept", 32'(seen), 1);
      @(posedge clk);
      #1 req_valid[0] = 1'b0;
      @(posedge clk);
      #2;
      chk("ar_inflight_lut_en", lut_en, 1);
      rst_n = 1'b0;
      #1;
      chk("ar_lut_en", lut_en, 0);
      chk("ar_lut_addr", lut_addr, 0);
      chk("ar_resp_valid", resp_valid, 0);
      chk("ar_req_ready", req_ready, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (8) begin
         @(negedge clk);
         chk("ar_no_resp", resp_valid, 0);
      end
      @(posedge clk);
      #1;
      single(1, 8'h08, 8'd68, "ar_after");

      for (int k = 0; k < 16; k++) rom[k] = 8'($urandom);
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         acc = req_ready;
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (acc[i] || !req_valid[i]) begin
               req_valid[i]    = ($urandom_range(0, 2) != 0);
               req_x[i*8 +: 8] = 8'($urandom);
            end
         end
         resp_ready = ($urandom_range(0, 3) != 0);
      end
      req_valid  = '0;
      resp_ready = 1'b1;
      wait_idle("rand");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/activation_lut_scheduler.md
Name: activation_lut_scheduler

Overview:
Shares one activation lookup table (synchronous ROM) and one linear-interpolation datapath between N_REQ neuron requesters in a layer. The block round-robin-arbitrates requests and splits each input x into a table index and a fractional remainder. It then fetches the base and next table entries on successive cycles, interpolates, and returns the result tagged with the requester id. It sits between the layer's neuron accumulators and the activation ROM.

Parameters:
N_REQ, 4, number of requesters (power of two, 2..8)
DATA_W, 8, signed width of x, table entries and result
FRAC_W, 4, low bits of x used as interpolation remainder
ADDR_W, 4, table index width (DATA_W-FRAC_W)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  N_REQ  per-requester request valid
req_x  in  N_REQ*DATA_W  packed signed inputs; requester i at [i*DATA_W +: DATA_W]
req_ready  out  N_REQ  one-hot acceptance strobe
lut_en  out  1  ROM read enable
lut_addr  out  ADDR_W  ROM address
lut_data  in  DATA_W  ROM read data, valid the cycle after lut_en/lut_addr
resp_valid  out  1  result valid
resp_ready  in  1  consumer ready
resp_id  out  clog2(N_REQ)  id of requester served
resp_value  out  DATA_W  signed interpolated result

Behaviour:
- Reset (async, rst_n=0): state IDLE, rr pointer=N_REQ-1, resp_valid=0, resp_id=0, resp_value=0, lut_en=0, lut_addr=0, req_ready=0. All internal registers clear.
- FSM states: IDLE -> RD_BASE -> RD_NEXT -> CALC -> RESP -> IDLE.
- IDLE: grant is the first i with req_valid[i]=1, searching circularly from pointer+1. req_ready[grant]=1 combinationally, and only in IDLE. On that edge, register x and id, set pointer=grant, go to RD_BASE. No request: stay in IDLE.
- Index mapping: idx = x[DATA_W-1:FRAC_W] with MSB inverted (offset binary), so x=-128 maps to 0 and x=127 maps to 15. rem = x[FRAC_W-1:0], unsigned.
- RD_BASE: lut_en=1, lut_addr=idx.
- RD_NEXT: capture lut_data as base. lut_en=1, lut_addr=idx+1, saturating at 2^ADDR_W-1 (idx=15 reads 15 again).
- CALC: lut_data is next. Register resp_value = base + ((sext(diff) * zext(rem)) >>> FRAC_W).
  - diff = (next-base) truncated to DATA_W (wraps).
  - The product is formed at DATA_W+FRAC_W bits.
  - The final sum is truncated to DATA_W (wraps, no saturation).
- RESP: resp_valid=1; resp_value and resp_id are held stable. On resp_valid&resp_ready, go to IDLE with resp_valid=0 on the next cycle.
- lut_en=0 in IDLE, CALC and RESP.
- Latency: resp_valid rises 3 cycles after the acceptance edge. Minimum 5 cycles per request. No new grant during RESP.
- Requests are not cancelled. The req_x of an accepted requester may change after acceptance without effect.
- Reset mid-operation: the in-flight request is dropped and no response is issued. Requesters must re-request.

Decomposition:
- Package act_sched_pkg: DATA_W/FRAC_W/ADDR_W constants, the state enum, and an idx_of(x) function.
- Interpolation arithmetic stays inline; it is identical to the layer interpolator's arithmetic.
- One sub-module, rr_arbiter (N_REQ, req_valid, pointer -> one-hot grant plus index), reused by other shared-resource schedulers.

Test Plan:
- ROM lut[k]=8*k. Requester 0 sends x=0x00 -> idx 8, lut_addr 8 then 9. resp_value=64, resp_id=0, 3 cycles after acceptance.
- Same ROM, x=0x08 -> 68. x=0x80 -> 0. x=0x7F -> next-address saturation: lut_addr 15 twice, resp_value=120.
- Wrap: lut[8]=100, lut[9]=-100, x=0x08. diff=-200 wraps to 56, 100+28 wraps to 0x80 -> resp_value=-128.
- All four req_valid held high. Acceptance order 0,1,2,3,0, with exactly one req_ready bit per grant and resp_id matching.
- resp_ready held low 10 cycles -> resp_valid/resp_value/resp_id stable, no new req_ready. Release -> IDLE, next grant one cycle later.
- Assert rst_n low during RD_NEXT -> outputs reset immediately (async), no response. After release, a new request completes normally.
